// File: rtl/alu_pkg.sv
// Shared definitions for the UART/ALU sequencing stage, the ALU and the bench:
// FSM state encodings, default widths and the ALU opcode set.
package alu_pkg;

  localparam int NB_DATA_DEF  = 8;
  localparam int NB_OP_DEF    = 6;
  localparam int NB_STATE_DEF = 3;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_WAIT_TX = 3'd4
  } state_e;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;

endpackage

// File: rtl/uart_alu_interface.sv
// Collects A, B and opcode bytes from the UART receiver, presents them to the ALU,
// then hands the ALU result to the UART transmitter and waits for it to finish.
module uart_alu_interface
  import alu_pkg::*;
#(
  parameter int NB_DATA  = NB_DATA_DEF,
  parameter int NB_OP    = NB_OP_DEF,
  parameter int NB_STATE = NB_STATE_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_a,
  output logic [NB_DATA-1:0] o_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_rx_drop
);

  localparam logic [NB_STATE-1:0] S_WAIT_A  = NB_STATE'(ST_WAIT_A);
  localparam logic [NB_STATE-1:0] S_WAIT_B  = NB_STATE'(ST_WAIT_B);
  localparam logic [NB_STATE-1:0] S_WAIT_OP = NB_STATE'(ST_WAIT_OP);
  localparam logic [NB_STATE-1:0] S_EXEC    = NB_STATE'(ST_EXEC);
  localparam logic [NB_STATE-1:0] S_WAIT_TX = NB_STATE'(ST_WAIT_TX);

  logic [NB_STATE-1:0] state_q,    state_d;
  logic [NB_DATA-1:0]  a_q,        a_d;
  logic [NB_DATA-1:0]  b_q,        b_d;
  logic [NB_OP-1:0]    op_q,       op_d;
  logic [NB_DATA-1:0]  tx_data_q,  tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                rx_drop_q,  rx_drop_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      rx_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      rx_drop_q  <= rx_drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    rx_drop_d  = 1'b0;

    case (state_q)
      S_WAIT_A: begin
        if (i_rx_done) begin
          a_d     = i_rx_data;
          state_d = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (i_rx_done) begin
          b_d     = i_rx_data;
          state_d = S_WAIT_OP;
        end
      end
      S_WAIT_OP: begin
        if (i_rx_done) begin
          op_d    = i_rx_data[NB_OP-1:0];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Operands have been stable on the ALU for a full cycle here.
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        rx_drop_d  = i_rx_done;
        state_d    = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        rx_drop_d = i_rx_done;
        if (i_tx_done) begin
          state_d = S_WAIT_A;
        end
      end
      default: begin
        state_d = S_WAIT_A;
      end
    endcase
  end

  assign o_a        = a_q;
  assign o_b        = b_q;
  assign o_op       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_rx_drop  = rx_drop_q;
  assign o_busy     = (state_q == S_EXEC) || (state_q == S_WAIT_TX);

endmodule

// File: tb/tb_uart_alu_interface.sv
// Closed-loop bench: a behavioural ALU feeds the DUT, and a byte-level model of the
// A/B/OP collection protocol predicts every registered output.
module tb_uart_alu_interface;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] alu_res;
  logic [7:0] o_a, o_b, o_tx_data;
  logic [5:0] o_op;
  logic       o_tx_start, o_busy, o_rx_drop;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference state: bytes collected so far (0..2) or 3 while a result is in flight.
  int         mp;
  logic [7:0] exp_a, exp_b, exp_tx;
  logic [5:0] exp_op;

  localparam logic [5:0] OPS [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR,
                                     OP_XOR, OP_NOR, OP_SRA, OP_SRL};

  uart_alu_interface #(.NB_DATA(8), .NB_OP(6), .NB_STATE(3)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .i_tx_done    (tx_done),
    .i_alu_result (alu_res),
    .o_a          (o_a),
    .o_b          (o_b),
    .o_op         (o_op),
    .o_tx_data    (o_tx_data),
    .o_tx_start   (o_tx_start),
    .o_busy       (o_busy),
    .o_rx_drop    (o_rx_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    int sa;
    case (op)
      OP_ADD: return 8'((int'(a) + int'(b)) % 256);
      OP_SUB: return 8'((int'(a) - int'(b) + 256) % 256);
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_XOR: return a ^ b;
      OP_NOR: return ~(a | b);
      OP_SRA: begin
        sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
        for (int i = 0; i < int'(b) && i < 8; i++) sa = (sa < 0) ? -((-sa + 1) / 2) : sa / 2;
        return 8'(sa);
      end
      OP_SRL: return (b >= 8'd8) ? 8'h00 : 8'(int'(a) / (1 << b));
      default: return 8'h00;
    endcase
  endfunction

  always_comb alu_res = alu_ref(o_a, o_b, o_op);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    chk_cnt++;
    if (obs === expv) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".a"},  o_a,  exp_a);
    check({tag, ".b"},  o_b,  exp_b);
    check({tag, ".op"}, o_op, exp_op);
  endtask

  // One receiver strobe; the model decides whether the byte lands or is dropped.
  task automatic send(input logic [7:0] d, input string tag);
    logic drop;
    rx_data = d;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    drop = (mp == 3);
    case (mp)
      0: exp_a = d;
      1: exp_b = d;
      2: exp_op = d[5:0];
      default: ;
    endcase
    if (mp < 3) mp++;
    check({tag, ".rx_drop"}, o_rx_drop, drop);
    check_regs(tag);
    $display("rx byte 0x%02h %s -> a=%02h b=%02h op=%02h", d, drop ? "dropped" : "taken",
             o_a, o_b, o_op);
  endtask

  task automatic idle(input int n, input bit spurious);
    repeat (n) begin
      tx_done = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      tx_done = 1'b0;
      check("idle.busy", o_busy, 1'b0);
      check("idle.tx_start", o_tx_start, 1'b0);
    end
  endtask

  // Full transaction: three bytes, result launch, optional drops, then tx completion.
  task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                     input int ndrop, input bit simul, input int gap, input string tag);
    send(a, {tag, ".A"});
    idle(gap, 1'b1);
    send(b, {tag, ".B"});
    idle(gap, 1'b1);
    send(opb, {tag, ".OP"});
    exp_tx = alu_ref(exp_a, exp_b, exp_op);
    check({tag, ".exec_busy"}, o_busy, 1'b1);
    check({tag, ".exec_start"}, o_tx_start, 1'b0);
    tick();
    check({tag, ".tx_start"}, o_tx_start, 1'b1);
    check({tag, ".tx_data"}, o_tx_data, exp_tx);
    check({tag, ".busy"}, o_busy, 1'b1);
    tick();
    check({tag, ".tx_start_off"}, o_tx_start, 1'b0);
    check({tag, ".busy_wait"}, o_busy, 1'b1);
    for (int i = 0; i < ndrop; i++) send(8'($urandom), {tag, ".DROP"});
    if (simul) begin
      rx_data = 8'h11;
      rx_done = 1'b1;
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    rx_done = 1'b0;
    mp = 0;
    check({tag, ".done_busy"}, o_busy, 1'b0);
    check({tag, ".done_drop"}, o_rx_drop, simul);
    check({tag, ".tx_data_hold"}, o_tx_data, exp_tx);
    check_regs({tag, ".done"});
    $display("txn %s a=%02h b=%02h op=%02h -> tx=%02h", tag, exp_a, exp_b, exp_op, o_tx_data);
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_done = 1'b0; tx_done = 1'b0;
    mp = 0; exp_a = '0; exp_b = '0; exp_op = '0; exp_tx = '0;
    repeat (3) @(posedge clk);
    #1;
    check_regs("reset");
    check("reset.tx_data", o_tx_data, 8'h00);
    check("reset.tx_start", o_tx_start, 1'b0);
    check("reset.busy", o_busy, 1'b0);
    check("reset.rx_drop", o_rx_drop, 1'b0);
    rst_n = 1'b1;
    tick();

    txn(8'h05, 8'h03, 8'h20, 0, 1'b0, 0, "add");
    check("add.result", o_tx_data, 8'h08);
    txn(8'h03, 8'h05, 8'h22, 0, 1'b0, 1, "sub");
    check("sub.result", o_tx_data, 8'hFE);
    txn(8'h80, 8'h02, 8'hC3, 0, 1'b0, 0, "sra");
    check("sra.op", o_op, 6'h03);
    check("sra.result", o_tx_data, 8'hE0);
    txn(8'h40, 8'h01, 8'h20, 1, 1'b0, 0, "drop");
    check("drop.a_kept", o_a, 8'h40);
    txn(8'h0F, 8'hF0, 8'h25, 0, 1'b0, 0, "or");
    check("or.result", o_tx_data, 8'hFF);
    txn(8'h01, 8'h02, 8'h26, 0, 1'b1, 0, "simul");
    send(8'h22, "after_simul");
    check("after_simul.a", o_a, 8'h22);

    // Asynchronous reset in the middle of a sequence.
    send(8'h09, "mid.B");
    #2 rst_n = 1'b0;
    #1;
    mp = 0; exp_a = '0; exp_b = '0; exp_op = '0; exp_tx = '0;
    check_regs("rst_mid");
    check("rst_mid.tx_data", o_tx_data, 8'h00);
    check("rst_mid.busy", o_busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    txn(8'h01, 8'h01, 8'h20, 0, 1'b0, 0, "post_rst");
    check("post_rst.result", o_tx_data, 8'h02);

    for (int t = 0; t < 24; t++) begin
      logic [7:0] opb;
      opb = {2'($urandom), OPS[$urandom_range(0, 7)]};
      txn(8'($urandom), 8'($urandom_range(0, 9)), opb, $urandom_range(0, 2),
          1'($urandom_range(0, 1)), $urandom_range(0, 2), "rand");
      if (mp == 0 && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3), 1'b1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
